// File: rtl/uart_cmd_master_if.sv
// Command-side handshake bundle for uart_cmd_master.
// The host drives one high-level command and its line config per valid/ready.
interface uart_cmd_master_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 CMD_VALID;
  logic                 CMD_READY;
  logic [1:0]           CMD_TYPE;
  logic [3:0]           ADDR;
  logic [7:0]           OP_A;
  logic [7:0]           OP_B;
  logic [3:0]           FUN;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic [CNT_WIDTH-1:0] CLKS_PER_BIT;

  modport master (
    output CMD_VALID,
    output CMD_TYPE,
    output ADDR,
    output OP_A,
    output OP_B,
    output FUN,
    output PAR_EN,
    output PAR_TYP,
    output CLKS_PER_BIT,
    input  CMD_READY
  );

  modport slave (
    input  CMD_VALID,
    input  CMD_TYPE,
    input  ADDR,
    input  OP_A,
    input  OP_B,
    input  FUN,
    input  PAR_EN,
    input  PAR_TYP,
    input  CLKS_PER_BIT,
    output CMD_READY
  );
endinterface

// File: rtl/uart_cmd_master.sv
// Expands one host command into protocol bytes and
// serialises them as UART frames on TX_SER.
module uart_cmd_master #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int GAP_BITS   = 1
) (
  input  logic             CLK,
  input  logic             RST,
  uart_cmd_master_if.slave cmd,
  output logic             TX_SER,
  output logic             BUSY,
  output logic             DONE
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_GAP
  } state_t;

  localparam logic [2:0] LAST_BIT = 3'(DATA_WIDTH - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_BITS - 1);

  state_t               r_state;
  logic [CNT_WIDTH-1:0] r_p;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [2:0]           r_bit;
  logic [1:0]           r_bidx;
  logic [1:0]           r_blast;
  logic [7:0]           r_gcnt;
  logic [3:0][7:0]      r_seq;
  logic                 r_par_en;
  logic                 r_par_typ;
  logic                 r_tx;
  logic                 r_done;

  logic [3:0][7:0]      w_seq;
  logic [1:0]           w_blast;
  logic [CNT_WIDTH-1:0] w_p;
  logic [7:0]           w_cur;
  logic                 w_tick;
  logic                 w_par;

  always_comb begin
    w_seq   = '0;
    w_blast = 2'd1;
    unique case (cmd.CMD_TYPE)
      2'd0: begin
        w_seq[0] = 8'hAA;
        w_seq[1] = {4'h0, cmd.ADDR};
        w_seq[2] = cmd.OP_A;
        w_blast  = 2'd2;
      end
      2'd1: begin
        w_seq[0] = 8'hBB;
        w_seq[1] = {4'h0, cmd.ADDR};
      end
      2'd2: begin
        w_seq[0] = 8'hCC;
        w_seq[1] = cmd.OP_A;
        w_seq[2] = cmd.OP_B;
        w_seq[3] = {4'h0, cmd.FUN};
        w_blast  = 2'd3;
      end
      2'd3: begin
        w_seq[0] = 8'hDD;
        w_seq[1] = {4'h0, cmd.FUN};
      end
    endcase
  end

  // A zero bit period would never tick; run it as one cycle per bit.
  assign w_p = (cmd.CLKS_PER_BIT == '0) ? CNT_WIDTH'(1)
                                        : cmd.CLKS_PER_BIT;

  assign w_cur  = r_seq[r_bidx];
  assign w_tick = (r_cnt == r_p - CNT_WIDTH'(1));
  assign w_par  = (^w_cur) ^ r_par_typ;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_p       <= '0;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_bidx    <= '0;
      r_blast   <= '0;
      r_gcnt    <= '0;
      r_seq     <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_tx      <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE)
        r_cnt <= '0;
      else
        r_cnt <= w_tick ? '0 : r_cnt + CNT_WIDTH'(1);

      unique case (r_state)
        S_IDLE: begin
          if (cmd.CMD_VALID) begin
            r_seq     <= w_seq;
            r_blast   <= w_blast;
            r_p       <= w_p;
            r_par_en  <= cmd.PAR_EN;
            r_par_typ <= cmd.PAR_TYP;
            r_bidx    <= '0;
            r_bit     <= '0;
            r_tx      <= 1'b0;
            r_state   <= S_START;
          end
        end
        S_START: begin
          if (w_tick) begin
            r_bit   <= '0;
            r_tx    <= w_cur[0];
            r_state <= S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_bit == LAST_BIT) begin
              if (r_par_en) begin
                r_tx    <= w_par;
                r_state <= S_PAR;
              end else begin
                r_tx    <= 1'b1;
                r_state <= S_STOP;
              end
            end else begin
              r_bit <= r_bit + 3'd1;
              r_tx  <= w_cur[r_bit + 3'd1];
            end
          end
        end
        S_PAR: begin
          if (w_tick) begin
            r_tx    <= 1'b1;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_bidx == r_blast) begin
              r_tx    <= 1'b1;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else if (GAP_BITS > 0) begin
              r_gcnt  <= '0;
              r_tx    <= 1'b1;
              r_state <= S_GAP;
            end else begin
              r_bidx  <= r_bidx + 2'd1;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end
          end
        end
        S_GAP: begin
          if (w_tick) begin
            if (r_gcnt == GAP_LAST) begin
              r_bidx  <= r_bidx + 2'd1;
              r_tx    <= 1'b0;
              r_state <= S_START;
            end else begin
              r_gcnt <= r_gcnt + 8'd1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd.CMD_READY = (r_state == S_IDLE);
  assign BUSY          = (r_state != S_IDLE);
  assign TX_SER        = r_tx;
  assign DONE          = r_done;

endmodule

// File: tb/tb_uart_cmd_master.sv
// Directed bench for uart_cmd_master: table of commands with
// hand-computed bytes, parity and durations, plus reset/b2b cases.
module tb_uart_cmd_master;

  logic CLK;
  logic RST;
  logic TX_SER;
  logic BUSY;
  logic DONE;

  uart_cmd_master_if #(.CNT_WIDTH(16)) cmd ();

  uart_cmd_master #(
    .DATA_WIDTH(8),
    .CNT_WIDTH (16),
    .GAP_BITS  (1)
  ) dut (
    .CLK   (CLK),
    .RST   (RST),
    .cmd   (cmd),
    .TX_SER(TX_SER),
    .BUSY  (BUSY),
    .DONE  (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  localparam int GAP = 1;

  typedef struct {
    logic [1:0]      typ;
    logic [3:0]      addr;
    logic [7:0]      opa;
    logic [7:0]      opb;
    logic [3:0]      fun;
    logic            pe;
    logic            pt;
    logic [15:0]     cpb;
    int              p;
    int              n;
    logic [3:0][7:0] b;
    logic [3:0]      par;
    int              t;
    bit              scr;
    bit              chn;
  } vec_t;

  int n_cmp = 0;
  int n_err = 0;
  bit exp_w[$];

  function automatic vec_t mk(
    int typ, int addr, int opa, int opb, int fun,
    int pe, int pt, int cpb, int p, int n,
    int b0, int b1, int b2, int b3,
    int par, int t, int scr, int chn);
    vec_t v;
    v.typ  = 2'(typ);
    v.addr = 4'(addr);
    v.opa  = 8'(opa);
    v.opb  = 8'(opb);
    v.fun  = 4'(fun);
    v.pe   = 1'(pe);
    v.pt   = 1'(pt);
    v.cpb  = 16'(cpb);
    v.p    = p;
    v.n    = n;
    v.b[0] = 8'(b0);
    v.b[1] = 8'(b1);
    v.b[2] = 8'(b2);
    v.b[3] = 8'(b3);
    v.par  = 4'(par);
    v.t    = t;
    v.scr  = (scr != 0);
    v.chn  = (chn != 0);
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    cmd.CMD_TYPE     = v.typ;
    cmd.ADDR         = v.addr;
    cmd.OP_A         = v.opa;
    cmd.OP_B         = v.opb;
    cmd.FUN          = v.fun;
    cmd.PAR_EN       = v.pe;
    cmd.PAR_TYP      = v.pt;
    cmd.CLKS_PER_BIT = v.cpb;
  endtask

  task automatic scramble();
    cmd.CMD_VALID    = 1'($urandom_range(0, 1));
    cmd.CMD_TYPE     = 2'($urandom);
    cmd.ADDR         = 4'($urandom);
    cmd.OP_A         = 8'($urandom);
    cmd.OP_B         = 8'($urandom);
    cmd.FUN          = 4'($urandom);
    cmd.PAR_EN       = 1'($urandom);
    cmd.PAR_TYP      = 1'($urandom);
    cmd.CLKS_PER_BIT = 16'($urandom_range(0, 9));
  endtask

  task automatic push_bit(bit val, int cnt);
    for (int i = 0; i < cnt; i++) exp_w.push_back(val);
  endtask

  // Expected line level for every cycle after the accept edge.
  task automatic build(vec_t v);
    exp_w.delete();
    for (int i = 0; i < v.n; i++) begin
      push_bit(1'b0, v.p);
      for (int j = 0; j < 8; j++) push_bit(v.b[i][j], v.p);
      if (v.pe) push_bit(v.par[i], v.p);
      push_bit(1'b1, v.p);
      if (i < v.n - 1) push_bit(1'b1, GAP * v.p);
    end
  endtask

  // Entry: at a negedge with v driven and CMD_VALID=1.
  // Exit: at the negedge of the DONE cycle.
  task automatic check_cmd(vec_t v, bit chain, vec_t nx,
                           string tag);
    int werr, first, rl, bh, de;
    werr = 0; first = -1; rl = 0; bh = 0; de = 0;
    chk({tag, ".ready_pre"}, 32'(cmd.CMD_READY), 1);
    build(v);
    @(posedge CLK);
    for (int k = 0; k <= v.t; k++) begin
      @(negedge CLK);
      if (k < v.t) begin
        if (k >= exp_w.size() || TX_SER !== exp_w[k]) begin
          werr++;
          if (first < 0) first = k;
        end
        if (cmd.CMD_READY !== 1'b0) rl++;
        if (BUSY !== 1'b1) bh++;
        if (DONE !== 1'b0) de++;
        if (v.scr) scramble();
        else if (k == 0 && !chain) cmd.CMD_VALID = 1'b0;
      end else begin
        chk({tag, ".done"}, 32'(DONE), 1);
        chk({tag, ".ready_end"}, 32'(cmd.CMD_READY), 1);
        chk({tag, ".busy_end"}, 32'(BUSY), 0);
        chk({tag, ".tx_end"}, 32'(TX_SER), 1);
        if (chain) begin
          drive(nx);
          cmd.CMD_VALID = 1'b1;
        end else begin
          cmd.CMD_VALID = 1'b0;
        end
      end
    end
    if (werr != 0)
      $display("FAIL %s.wave_first: got %0d want -1", tag, first);
    chk({tag, ".wave_err"}, 32'(werr), 0);
    chk({tag, ".ready_low"}, 32'(rl), 0);
    chk({tag, ".busy_high"}, 32'(bh), 0);
    chk({tag, ".done_early"}, 32'(de), 0);
  endtask

  task automatic check_idle(string tag, int cyc);
    int bad;
    bad = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge CLK);
      if (TX_SER !== 1'b1 || BUSY !== 1'b0 ||
          DONE !== 1'b0) bad++;
    end
    chk({tag, ".idle"}, 32'(bad), 0);
  endtask

  vec_t tv[6];
  vec_t rv;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pend;
    int werr;
    RST = 1'b1;
    cmd.CMD_VALID = 1'b0;
    drive(mk(0,0,0,0,0,0,0,1,1,2,0,0,0,0,0,0,0,0));

    tv[0] = mk(0,4,'h5A,0,0, 0,0,4, 4,3,
               'hAA,'h04,'h5A,0, 'b0000,128,1,0);
    tv[1] = mk(2,0,'h03,'h07,1, 1,0,2, 2,4,
               'hCC,'h03,'h07,'h01, 'b1100,94,0,0);
    tv[2] = mk(1,2,0,0,0, 1,1,1, 1,2,
               'hBB,'h02,0,0, 'b0001,23,1,0);
    tv[3] = mk(3,0,0,0,'hA, 0,0,0, 1,2,
               'hDD,'h0A,0,0, 'b0000,21,0,1);
    tv[4] = mk(0,'hF,'h81,0,0, 1,0,3, 3,3,
               'hAA,'h0F,'h81,0, 'b0000,105,0,0);
    tv[5] = mk(2,0,'hFF,'h00,'hF, 1,1,1, 1,4,
               'hCC,'hFF,'h00,'h0F, 'b1111,47,0,0);
    rv    = mk(0,4,'h5A,0,0, 0,0,2, 2,3,
               'hAA,'h04,'h5A,0, 'b0000,64,0,0);

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst.tx", 32'(TX_SER), 1);
    chk("rst.ready", 32'(cmd.CMD_READY), 1);
    chk("rst.busy", 32'(BUSY), 0);
    chk("rst.done", 32'(DONE), 0);
    RST = 1'b0;
    check_idle("post_rst", 3);

    pend = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!pend) begin
        @(negedge CLK);
        drive(tv[i]);
        cmd.CMD_VALID = 1'b1;
      end
      check_cmd(tv[i], tv[i].chn, tv[(i + 1) % 6],
                $sformatf("v%0d", i));
      pend = tv[i].chn;
      if (!pend) check_idle($sformatf("v%0d", i), 6);
    end

    // Reset during bit 2 of the second byte of a WRITE.
    build(rv);
    werr = 0;
    @(negedge CLK);
    drive(rv);
    cmd.CMD_VALID = 1'b1;
    @(posedge CLK);
    for (int k = 0; k <= 28; k++) begin
      @(negedge CLK);
      if (TX_SER !== exp_w[k]) werr++;
      if (k == 0) cmd.CMD_VALID = 1'b0;
    end
    chk("mid.prefix_err", 32'(werr), 0);
    chk("mid.busy_before", 32'(BUSY), 1);
    RST = 1'b1;
    @(negedge CLK);
    chk("mid.tx", 32'(TX_SER), 1);
    chk("mid.busy", 32'(BUSY), 0);
    chk("mid.ready", 32'(cmd.CMD_READY), 1);
    chk("mid.done", 32'(DONE), 0);
    RST = 1'b0;
    check_idle("mid_after", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
